// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFix,
        StDone
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or, with MULDIV_DIV_EN, restoring divide.
// Operates on unsigned magnitudes; acc/q form the double-width working register.
module muldiv_step #(
    parameter int WIDTH = 32
) (
`ifdef MULDIV_DIV_EN
    input  logic             i_div,
`endif
    input  logic [WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_m,
    output logic [WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH:0] w_sum;

    assign w_sum = {1'b0, i_acc} + (i_q[0] ? {1'b0, i_m} : {(WIDTH + 1){1'b0}});

`ifdef MULDIV_DIV_EN
    logic [WIDTH:0] w_sh;
    logic [WIDTH:0] w_diff;

    assign w_sh   = {i_acc, i_q[WIDTH-1]};
    assign w_diff = w_sh - {1'b0, i_m};
`endif

    always_comb begin
        o_acc = w_sum[WIDTH:1];
        o_q   = {w_sum[0], i_q[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
        if (i_div) begin
            // Borrow out of the W+1-bit subtract means the divisor did not fit.
            if (!w_diff[WIDTH]) begin
                o_acc = w_diff[WIDTH-1:0];
                o_q   = {i_q[WIDTH-2:0], 1'b1};
            end else begin
                o_acc = w_sh[WIDTH-1:0];
                o_q   = {i_q[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers, one bit per cycle.
// Divide support is built only when MULDIV_DIV_EN is defined.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero,
    output logic             op_err
);

    localparam int CntW = $clog2(WIDTH + 1);

    function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v, input logic is_signed);
        return (is_signed && v[WIDTH-1]) ? -v : v;
    endfunction

    state_t r_state, w_state_next;

    logic [CntW-1:0]    r_cnt;
    logic               r_is_div;
    logic               r_a_neg;
    logic               r_b_neg;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_m;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_dbz;
`ifdef MULDIV_DIV_EN
    logic [WIDTH-1:0]   r_a;
    logic               r_b_zero;
`else
    logic               r_op_err;
`endif

    logic               w_idle_or_done;
    logic               w_accept;
    logic               w_wr_ok;
    logic [WIDTH-1:0]   w_acc_next;
    logic [WIDTH-1:0]   w_q_next;
    logic [2*WIDTH-1:0] w_prod_mag;
    logic [2*WIDTH-1:0] w_prod;

    assign w_idle_or_done = (r_state == StIdle) || (r_state == StDone);
    assign w_accept       = start && w_idle_or_done;
    assign w_wr_ok        = w_idle_or_done && !w_accept;
    assign w_prod_mag     = {r_acc, r_q};
    assign w_prod         = (r_a_neg ^ r_b_neg) ? -w_prod_mag : w_prod_mag;

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
`ifdef MULDIV_DIV_EN
        .i_div (r_is_div),
`endif
        .i_acc (r_acc),
        .i_q   (r_q),
        .i_m   (r_m),
        .o_acc (w_acc_next),
        .o_q   (w_q_next)
    );

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_accept) w_state_next = StRun;
            StRun:   if (r_cnt == CntW'(1)) w_state_next = StFix;
            StFix:   w_state_next = StDone;
            StDone:  w_state_next = w_accept ? StRun : StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= StIdle;
        else       r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_a_neg  <= 1'b0;
            r_b_neg  <= 1'b0;
            r_acc    <= '0;
            r_q      <= '0;
            r_m      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_dbz    <= 1'b0;
`ifdef MULDIV_DIV_EN
            r_a      <= '0;
            r_b_zero <= 1'b0;
`else
            r_op_err <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_cnt    <= CntW'(WIDTH);
                r_is_div <= op[1];
                r_a_neg  <= op[0] && a[WIDTH-1];
                r_b_neg  <= op[0] && b[WIDTH-1];
                r_acc    <= '0;
                // Multiply iterates over the multiplier; divide shifts in the dividend.
                r_q      <= op[1] ? f_mag(a, op[0]) : f_mag(b, op[0]);
                r_m      <= op[1] ? f_mag(b, op[0]) : f_mag(a, op[0]);
                r_dbz    <= 1'b0;
`ifdef MULDIV_DIV_EN
                r_a      <= a;
                r_b_zero <= (b == '0);
`else
                r_op_err <= 1'b0;
`endif
            end else if (r_state == StRun) begin
                r_acc <= w_acc_next;
                r_q   <= w_q_next;
                r_cnt <= r_cnt - CntW'(1);
            end else if (r_state == StFix) begin
                if (!r_is_div) begin
                    r_hi <= w_prod[2*WIDTH-1:WIDTH];
                    r_lo <= w_prod[WIDTH-1:0];
                end
`ifdef MULDIV_DIV_EN
                else if (r_b_zero) begin
                    r_hi  <= r_a;
                    r_lo  <= '1;
                    r_dbz <= 1'b1;
                end else begin
                    // Remainder follows the dividend; MIN/-1 wraps back to MIN.
                    r_hi <= r_a_neg ? -r_acc : r_acc;
                    r_lo <= (r_a_neg ^ r_b_neg) ? -r_q : r_q;
                end
`else
                else begin
                    r_op_err <= 1'b1;
                end
`endif
            end

            if (w_wr_ok && hi_we) r_hi <= wdata;
            if (w_wr_ok && lo_we) r_lo <= wdata;
        end
    end

    assign busy        = (r_state == StRun) || (r_state == StFix);
    assign done        = (r_state == StDone);
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign div_by_zero = r_dbz;
`ifdef MULDIV_DIV_EN
    assign op_err      = 1'b0;
`else
    assign op_err      = r_op_err;
`endif

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WIDTH = 32); adapts divide expectations to MULDIV_DIV_EN.
module tb_muldiv_unit;
    import muldiv_pkg::*;

`ifdef MULDIV_DIV_EN
    localparam bit DivEn = 1'b1;
`else
    localparam bit DivEn = 1'b0;
`endif
    localparam logic [31:0] PreHi = 32'hAAAA5555;
    localparam logic [31:0] PreLo = 32'h00001234;

    logic        clk = 1'b0;
    logic        reset, start, hi_we, lo_we;
    logic [1:0]  op;
    logic [31:0] a, b, wdata;
    logic        busy, done, div_by_zero, op_err;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_errors = 0;

    muldiv_unit #(
        .WIDTH (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero),
        .op_err      (op_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic preset(input logic [31:0] h, input logic [31:0] l);
        @(negedge clk); hi_we = 1'b1; wdata = h;
        @(negedge clk); hi_we = 1'b0; lo_we = 1'b1; wdata = l;
        @(negedge clk); lo_we = 1'b0;
    endtask

    // Caller is between edges; returns #1 after the accepting edge.
    task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Counts edges until done, starting #1 after the accepting edge.
    task automatic wait_done(output int lat, output int busy_n);
        lat = 0;
        busy_n = busy ? 1 : 0;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (busy) busy_n++;
        end
    endtask

    initial begin
        int lat, bn, dn;
        logic [31:0] eh, el;

        vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
        vecs[2]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[3]  = '{OP_MULT,  32'd7,        32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0};
        vecs[4]  = '{OP_MULTU, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780, 1'b0};
        vecs[5]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[6]  = '{OP_DIVU,  32'd7,        32'd2,        32'd1,        32'd3,        1'b0};
        vecs[7]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[8]  = '{OP_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1};
        vecs[9]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
        vecs[10] = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        vecs[11] = '{OP_DIV,   32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1};

        reset = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = '0; a = '0; b = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset hi", hi, 32'h0);
        chk("reset lo", lo, 32'h0);
        chk("reset busy", {31'b0, busy}, 32'h0);
        chk("reset done", {31'b0, done}, 32'h0);
        chk("reset dbz", {31'b0, div_by_zero}, 32'h0);
        chk("reset op_err", {31'b0, op_err}, 32'h0);
        @(negedge clk); reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            preset(PreHi, PreLo);
            launch(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(lat, bn);
            eh = (vecs[i].op[1] && !DivEn) ? PreHi : vecs[i].hi;
            el = (vecs[i].op[1] && !DivEn) ? PreLo : vecs[i].lo;
            chk($sformatf("v%0d latency", i), lat, 32'd33);
            chk($sformatf("v%0d busy cycles", i), bn, 32'd33);
            chk($sformatf("v%0d hi", i), hi, eh);
            chk($sformatf("v%0d lo", i), lo, el);
            chk($sformatf("v%0d dbz", i), {31'b0, div_by_zero}, {31'b0, vecs[i].dbz & DivEn});
            chk($sformatf("v%0d op_err", i), {31'b0, op_err}, {31'b0, vecs[i].op[1] & ~DivEn});
        end

        // Flags from a divide-by-zero / unsupported op clear on the next accept.
        preset(32'h0, 32'h0);
        launch(OP_DIVU, 32'd5, 32'd0);
        wait_done(lat, bn);
        chk("dbz set", {31'b0, div_by_zero}, {31'b0, DivEn});
        chk("op_err set", {31'b0, op_err}, {31'b0, ~DivEn});
        launch(OP_MULTU, 32'd1, 32'd1);
        chk("dbz cleared", {31'b0, div_by_zero}, 32'h0);
        chk("op_err cleared", {31'b0, op_err}, 32'h0);
        wait_done(lat, bn);

        // Back-to-back: start issued in the DONE cycle.
        @(negedge clk);
        launch(OP_MULT, 32'hFFFFFFFD, 32'd5);
        wait_done(lat, bn);
        chk("b2b first hi", hi, 32'hFFFFFFFF);
        chk("b2b first lo", lo, 32'hFFFFFFF1);
        launch(OP_MULT, 32'h80000000, 32'h80000000);
        chk("b2b accepted busy", {31'b0, busy}, 32'h1);
        wait_done(lat, bn);
        chk("b2b latency", lat, 32'd33);
        chk("b2b second hi", hi, 32'h40000000);
        chk("b2b second lo", lo, 32'h0);
        @(posedge clk); #1;
        chk("done one cycle", {31'b0, done}, 32'h0);

        // Start pulse mid-run is ignored; operands stay latched.
        @(negedge clk);
        launch(OP_MULTU, 32'd7, 32'd6);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; op = OP_MULTU; a = 32'd1000; b = 32'd1000;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat, bn);
        chk("ignored start latency", lat + 5, 32'd33);
        chk("ignored start lo", lo, 32'd42);
        chk("ignored start hi", hi, 32'd0);

        // Write collides with an accepting start: dropped.
        preset(PreHi, PreLo);
        @(negedge clk);
        lo_we = 1'b1; wdata = 32'hCAFEF00D;
        launch(OP_MULTU, 32'd2, 32'd3);
        lo_we = 1'b0;
        chk("write on accept dropped", lo, PreLo);

        // Write during RUN: dropped.
        repeat (3) @(posedge clk);
        #1;
        lo_we = 1'b1; wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        lo_we = 1'b0;
        chk("write in run dropped", lo, PreLo);
        wait_done(lat, bn);
        chk("run after drop lo", lo, 32'd6);

        // Reset at cycle 10 of a run: abandon, no done pulse.
        preset(PreHi, PreLo);
        launch(OP_MULTU, 32'd3, 32'd3);
        repeat (9) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mid reset busy", {31'b0, busy}, 32'h0);
        chk("mid reset hi", hi, 32'h0);
        chk("mid reset lo", lo, 32'h0);
        dn = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) dn++;
        end
        chk("mid reset no done", dn, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (even, >=4).
REQ-002 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port start  in  1  request to begin an operation; sampled each edge.
REQ-005 SHALL have port op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 SHALL have ports a, b  in  WIDTH  multiplicand/dividend, multiplier/divisor.
REQ-007 SHALL have ports hi_we, lo_we  in  1  MTHI/MTLO write strobes; port wdata  in  WIDTH  their data.
REQ-008 SHALL have port busy  out  1  operation in progress.
REQ-009 SHALL have port done  out  1  one-cycle completion pulse.
REQ-010 SHALL have ports hi, lo  out  WIDTH  registered HI/LO result registers.
REQ-011 SHALL have port div_by_zero  out  1  sticky flag for the last completed operation.
REQ-012 SHALL have port op_err  out  1  unsupported operation flag for the last completed operation.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, FIX, DONE.
REQ-014 SHALL accept start only in IDLE or DONE; accepting edge latches op, a, b and moves to RUN with bit counter = WIDTH.
REQ-015 SHALL ignore start in RUN/FIX; latched operands are unaffected.
REQ-016 SHALL process one bit per RUN edge (shift-add multiply, restoring divide on magnitudes); after WIDTH RUN edges go to FIX.
REQ-017 SHALL, on the FIX edge, apply sign correction (signed ops), write hi/lo, and go to DONE; unsigned ops pass through FIX so latency is constant.
REQ-018 SHALL assert busy in RUN and FIX only, and done only in DONE; done rises WIDTH+1 edges after the accepting edge, for exactly one cycle.
REQ-019 SHALL go from DONE to RUN if start is accepted there, otherwise to IDLE.
REQ-020 Multiply SHALL give {hi,lo} = full 2*WIDTH product, signed for MULT.
REQ-021 Divide SHALL give lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
REQ-022 DIV of most-negative by -1 SHALL give lo = most-negative and hi = 0, with no flag.
REQ-023 Divide by b = 0 SHALL give lo = all ones and hi = a, and set div_by_zero at the FIX edge.
REQ-024 div_by_zero and op_err SHALL be cleared on each accepting edge.
REQ-025 hi_we/lo_we SHALL write wdata at the next edge only in IDLE or DONE; they SHALL be dropped in RUN/FIX or when start is accepted on the same edge.

Reset
REQ-026 reset SHALL force IDLE, hi = lo = 0, busy = done = div_by_zero = op_err = 0, and counter = 0.
REQ-027 reset SHALL take priority over start and writes, and mid-operation it SHALL abandon the operation with no done pulse.

Configuration
REQ-028 Macro MULDIV_DIV_EN SHALL select divide support.
REQ-029 With MULDIV_DIV_EN defined, the divider datapath SHALL be present and op_err SHALL be constant 0.
REQ-030 Without MULDIV_DIV_EN, no divider logic SHALL exist; DIVU/DIV SHALL follow the same FSM and latency, leave hi/lo unchanged, and set op_err = 1 at the FIX edge.

Structure
REQ-031 Package muldiv_pkg SHALL hold the op encodings (OP_MULTU, OP_MULT, OP_DIVU, OP_DIV) and the FSM state type.
REQ-032 Sub-module muldiv_step SHALL hold the combinational single-iteration add/subtract-and-shift step, shared by multiply and divide.

Verification (WIDTH = 32)
REQ-033 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001; done exactly 33 edges after the accepting edge; busy high for 33 cycles.
REQ-034 MULT -3 x 5 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFF1; then back-to-back start in the DONE cycle with MULT 0x80000000 x 0x80000000 -> hi = 0x40000000, lo = 0.
REQ-035 DIV -7/2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; DIVU 7/2 -> lo = 3, hi = 1; DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
REQ-036 DIVU 5/0 -> lo = 0xFFFFFFFF, hi = 5, div_by_zero = 1; the next accepted start clears div_by_zero.
REQ-037 start pulse at cycle 5 of a run -> ignored, result unchanged; lo_we in RUN -> dropped; reset at cycle 10 -> IDLE, hi = lo = 0, no done.
REQ-038 Build without MULDIV_DIV_EN: DIVU 7/2 after MTLO 0x1234 -> lo = 0x1234 unchanged, op_err = 1, done at the same latency.
